// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch front end. Holds the fetch PC, issues one word
//            read at a time to instruction memory over req/ack, buffers the
//            returned words in a small FIFO and presents the FIFO head to the
//            decoder over valid/ready. A redirect flushes the FIFO and any
//            in-flight response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC    first fetch address after reset (word aligned)
//   FIFO_DEPTH  instruction buffer entries, 2 or 4
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   imem_req/imem_addr    read request and word-aligned address
//   imem_ack/imem_rdata   read completion and returned word
//   instr_valid/ready     decode handshake on the FIFO head
//   instr, opcode         head word and its [31:26] opcode field
//   instr_pc, pc_plus4    head address and head address + 4
//   redirect/redirect_pc  taken branch/jump and its target
// Optional feature (macro FETCH_PERF_CNT_EN)
//   perf_fetched          count of instructions accepted by decode
//   perf_flushed          count of instructions/responses discarded
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic               req_q,      req_d;
  logic [31:0]        addr_q,     addr_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [31:0]        pc_mem_q  [FIFO_DEPTH];
  logic [31:0]        ins_mem_q [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic [31:0] target;
  logic        unused_redirect_lsb;

  assign target              = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? ins_mem_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]  : 32'h0;
  assign pc_plus4    = instr_pc + 32'd4;
  assign opcode      = instr[31:26];
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;

  // A redirect kills any pop in the same cycle.
  assign pop = instr_valid && instr_ready && !redirect;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Nothing is outstanding here, so free space is simply count < depth.
        // A redirect takes this cycle to load the new target first.
        if (redirect) begin
          fetch_pc_d = target;
        end else if (count_q < C_DEPTH) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          if (redirect) begin
            fetch_pc_d = target;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          fetch_pc_d = target;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The wrong-path response is thrown away; the newest target wins.
        if (redirect) begin
          fetch_pc_d = target;
        end
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]  <= 32'h0;
        ins_mem_q[i] <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]  <= addr_q;
        ins_mem_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + (pop ? 32'd1 : 32'd0);
    perf_flushed_d = perf_flushed_q;
    // The outstanding response is charged once, when the redirect hits REQ;
    // a further redirect during DRAIN only adds the (empty) FIFO contents.
    if (redirect) begin
      perf_flushed_d = perf_flushed_q + {{(32-CNT_W){1'b0}}, count_q}
                     + ((state_q == S_REQ) ? 32'd1 : 32'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= 32'h0;
      perf_flushed_q <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit. A second
//            instance with a high RESET_PC exercises fetch PC wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_instr;
  logic [5:0]  w_opcode;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
  logic [31:0] w_perf_fetched, w_perf_flushed;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int wait_cnt = 0;
  int lat      = 0;
  logic ack_en = 1'b0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr(w_instr), .opcode(w_opcode), .instr_pc(w_pc), .pc_plus4(w_pc4),
    .redirect(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: opcode = addr[7:2]^6'h2A, low bits = addr[25:0]^26'h0123456.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2] ^ 6'h2A, a[25:0] ^ 26'h0123456};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock of the main DUT with an auto-responding memory; redirect is a one-cycle pulse.
  task automatic cyc();
    if (imem_req && ack_en && wait_cnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wait_cnt   = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h5555_5555;
      wait_cnt   = imem_req ? wait_cnt + 1 : 0;
    end
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    ack_en = 1'b0; wait_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 20) begin
      cyc();
      n++;
    end
    check(tag, {31'h0, imem_req}, 32'h1);
  endtask

  initial begin
    logic [31:0] exp_pc, exp_addr;
    logic        prev_req;
    int          n_req;
    logic [31:0] wa_tbl [3];
    logic [31:0] wp4_tbl[3];
    logic [5:0]  wop_tbl[3];
    int          wi_req, wi_pop;

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; w_ack = 1'b0; w_rdata = 32'h0; w_ready = 1'b1;

    // ---- 1: steady streaming, ack one cycle after req ----
    @(posedge clk); #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    rst = 1'b0;
    ack_en = 1'b1; lat = 1; instr_ready = 1'b1;
    cyc();
    check("t1_req_latency", {31'h0, imem_req}, 32'h1);
    check("t1_addr0", imem_addr, 32'h0);
    cyc();
    check("t1_valid_before_ack", {31'h0, instr_valid}, 32'h0);
    cyc();
    check("t1_valid_after_ack", {31'h0, instr_valid}, 32'h1);
    check("t1_instr0", instr, 32'hA812_3456);
    check("t1_opcode0", {26'h0, opcode}, 32'h2A);
    check("t1_pc0", instr_pc, 32'h0);
    check("t1_pc4_0", pc_plus4, 32'h4);
    check("t1_req_dropped", {31'h0, imem_req}, 32'h0);
    exp_pc = 32'h0; exp_addr = 32'h4; prev_req = imem_req;
    for (int i = 0; i < 24; i++) begin
      if (imem_req && !prev_req) begin
        check("t1_addr_seq", imem_addr, exp_addr);
        exp_addr += 4;
      end
      if (instr_valid && instr_ready) begin
        check("t1_pc_seq", instr_pc, exp_pc);
        check("t1_instr_seq", instr, mem_word(exp_pc));
        check("t1_opcode_seq", {26'h0, opcode}, {26'h0, exp_pc[7:2] ^ 6'h2A});
        exp_pc += 4;
      end
      prev_req = imem_req;
      cyc();
    end
    check("t1_progress", {31'h0, (exp_pc >= 32'h10)}, 32'h1);

    // ---- 2: decode stalled, FIFO fills after FIFO_DEPTH words ----
    do_reset();
    ack_en = 1'b1; lat = 0; instr_ready = 1'b0;
    n_req = 0; exp_addr = 32'h0; prev_req = imem_req;
    for (int i = 0; i < 12; i++) begin
      if (imem_req && !prev_req) begin
        check("t2_addr_seq", imem_addr, exp_addr);
        exp_addr += 4;
        n_req++;
      end
      prev_req = imem_req;
      cyc();
    end
    check("t2_num_reqs", n_req, 32'd2);
    check("t2_req_idle", {31'h0, imem_req}, 32'h0);
    check("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    cyc();
    check("t2_pop_head", instr_pc, 32'h4);
    check("t2_no_req_yet", {31'h0, imem_req}, 32'h0);
    cyc();
    check("t2_resume_req", {31'h0, imem_req}, 32'h1);
    check("t2_resume_addr", imem_addr, 32'h8);

    // ---- 3: redirect while waiting for ack -> DRAIN ----
    do_reset();
    instr_ready = 1'b1; ack_en = 1'b0;
    wait_req("t3_req");
    check("t3_addr0", imem_addr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    cyc();
    check("t3_drain_req", {31'h0, imem_req}, 32'h1);
    check("t3_drain_addr", imem_addr, 32'h0);
    cyc();
    check("t3_drain_hold", {31'h0, imem_req}, 32'h1);
    ack_en = 1'b1; lat = 0;
    cyc();
    check("t3_drain_done_req", {31'h0, imem_req}, 32'h0);
    check("t3_discard_valid", {31'h0, instr_valid}, 32'h0);
    cyc();
    check("t3_discard_valid2", {31'h0, instr_valid}, 32'h0);
    check("t3_target_req", {31'h0, imem_req}, 32'h1);
    check("t3_target_addr", imem_addr, 32'h0000_0040);
    cyc();
    check("t3_target_pc", instr_pc, 32'h0000_0040);
    check("t3_target_instr", instr, 32'hE812_3416);

    // ---- 3b: second redirect during DRAIN wins ----
    do_reset();
    ack_en = 1'b0;
    wait_req("t3b_req");
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0107;
    cyc();
    ack_en = 1'b1; lat = 0;
    cyc();
    wait_req("t3b_req2");
    check("t3b_latest_target", imem_addr, 32'h0000_0104);

    // ---- 4: redirect + ack + pop in one cycle, FIFO holding one entry ----
    do_reset();
    instr_ready = 1'b0; ack_en = 1'b1; lat = 0;
    for (int n = 0; n < 10 && !instr_valid; n++) cyc();
    check("t4_one_entry", {31'h0, instr_valid}, 32'h1);
    ack_en = 1'b0;
    wait_req("t4_req");
    check("t4_addr", imem_addr, 32'h4);
    check("t4_head", instr_pc, 32'h0);
    ack_en = 1'b1; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cyc();
    check("t4_flushed_valid", {31'h0, instr_valid}, 32'h0);
    check("t4_req_low", {31'h0, imem_req}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("t4_perf_flushed", perf_flushed, 32'd2);
    check("t4_perf_fetched", perf_fetched, 32'd0);
`endif
    instr_ready = 1'b0;
    cyc();
    check("t4_target_req", {31'h0, imem_req}, 32'h1);
    check("t4_target_addr", imem_addr, 32'h0000_0200);

    // ---- 5: fetch PC wrap on the high-RESET_PC instance ----
    do_reset();
    wa_tbl  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    wp4_tbl = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    wop_tbl = '{6'h14, 6'h15, 6'h2A};
    wi_req = 0; wi_pop = 0; prev_req = w_req; w_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (w_req && !prev_req && wi_req < 3) begin
        check("t5_addr_seq", w_addr, wa_tbl[wi_req]);
        wi_req++;
      end
      if (w_valid && w_ready && wi_pop < 3) begin
        check("t5_pc_seq", w_pc, wa_tbl[wi_pop]);
        check("t5_pc4_seq", w_pc4, wp4_tbl[wi_pop]);
        check("t5_opcode_seq", {26'h0, w_opcode}, {26'h0, wop_tbl[wi_pop]});
        check("t5_instr_seq", w_instr, mem_word(wa_tbl[wi_pop]));
        wi_pop++;
      end
      prev_req = w_req;
      w_ack    = w_req;
      w_rdata  = mem_word(w_addr);
      @(posedge clk); #1;
    end
    w_ack = 1'b0;
    check("t5_num_reqs", wi_req, 32'd3);
    check("t5_num_pops", wi_pop, 32'd3);

    // ---- 6: reset while a request is waiting, stray ack afterwards ----
    do_reset();
    instr_ready = 1'b1; ack_en = 1'b0;
    wait_req("t6_req");
    rst = 1'b1;
    #1;
    check("t6_rst_req", {31'h0, imem_req}, 32'h0);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
    check("t6_rst_pc4", pc_plus4, 32'h4);
`ifdef FETCH_PERF_CNT_EN
    check("t6_rst_perf_fetched", perf_fetched, 32'h0);
    check("t6_rst_perf_flushed", perf_flushed, 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    check("t6_first_req", {31'h0, imem_req}, 32'h1);
    check("t6_first_addr", imem_addr, 32'h0);
    check("t6_stray_valid", {31'h0, instr_valid}, 32'h0);
    @(posedge clk); #1;
    check("t6_stray_not_pushed", {31'h0, instr_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
